// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the ALU operand issue stage
package alu_issue_pkg;
  localparam int ALU_INSTR_W = 4;
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: generic synchronous FIFO with registered count, full and empty
module alu_issue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU ops, drives the head to the ALU with chained carry, registers the result
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int REG_WIDTH = 4,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [REG_WIDTH-1:0]   in_a_i,
  input  logic [REG_WIDTH-1:0]   in_b_i,
  input  logic [ALU_INSTR_W-1:0] in_instr_i,
  input  logic                   in_cin_i,
  input  logic                   in_use_carry_i,
  output logic [REG_WIDTH-1:0]   alu_a_o,
  output logic [REG_WIDTH-1:0]   alu_b_o,
  output logic [ALU_INSTR_W-1:0] alu_instr_o,
  output logic                   alu_cin_o,
  input  logic [REG_WIDTH-1:0]   alu_out_i,
  input  logic                   alu_cout_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [REG_WIDTH-1:0]   res_out_o,
  output logic                   res_cout_o
);
  typedef struct packed {
    logic [REG_WIDTH-1:0]   a;
    logic [REG_WIDTH-1:0]   b;
    logic [ALU_INSTR_W-1:0] instr;
    logic                   cin;
    logic                   use_carry;
  } entry_t;
  entry_t                       w_in;
  entry_t                       w_head;
  logic                         w_full;
  logic                         w_empty;
  logic [$clog2(DEPTH+1)-1:0]   w_count;
  logic                         w_issue;
  logic                         r_carry;
  assign w_in       = {in_a_i, in_b_i, in_instr_i, in_cin_i, in_use_carry_i};
  assign in_ready_o = !w_full;
  assign w_issue    = (w_count != '0) && (!res_valid_o || res_ready_i);
  alu_issue_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid_i && in_ready_o),
    .i_pop   (w_issue),
    .i_wdata (w_in),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_comb begin
    alu_a_o     = w_empty ? '0 : w_head.a;
    alu_b_o     = w_empty ? '0 : w_head.b;
    alu_instr_o = w_empty ? '0 : w_head.instr;
    alu_cin_o   = !w_empty && (w_head.use_carry ? r_carry : w_head.cin);
  end
  // A pending result with ready and no issue can only mean the FIFO is empty, so it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_o <= 1'b0;
      res_out_o   <= '0;
      res_cout_o  <= 1'b0;
      r_carry     <= 1'b0;
    end else if (w_issue) begin
      res_valid_o <= 1'b1;
      res_out_o   <= alu_out_i;
      res_cout_o  <= alu_cout_i;
      r_carry     <= alu_cout_i;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed stimulus checked against a queue-based model every cycle plus literal expectations
module tb_alu_issue_stage;
  localparam int RW = 4;
  localparam int D  = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [RW-1:0] in_a_i = '0;
  logic [RW-1:0] in_b_i = '0;
  logic [3:0]    in_instr_i = '0;
  logic          in_cin_i = 1'b0;
  logic          in_use_carry_i = 1'b0;
  logic [RW-1:0] alu_a_o;
  logic [RW-1:0] alu_b_o;
  logic [3:0]    alu_instr_o;
  logic          alu_cin_o;
  logic [RW-1:0] alu_out_i;
  logic          alu_cout_i;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic [RW-1:0] res_out_o;
  logic          res_cout_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  // Bench ALU: opcode 0 adds with carry, anything else is xor with no carry-out.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] instr, input logic cin);
    return (instr == 4'h0) ? ({1'b0, a} + {1'b0, b} + {4'b0, cin}) : {1'b0, a ^ b};
  endfunction
  assign {alu_cout_i, alu_out_i} = alu(alu_a_o, alu_b_o, alu_instr_o, alu_cin_o);

  alu_issue_stage #(.REG_WIDTH(RW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_instr_i(in_instr_i),
    .in_cin_i(in_cin_i), .in_use_carry_i(in_use_carry_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_instr_o(alu_instr_o), .alu_cin_o(alu_cin_o),
    .alu_out_i(alu_out_i), .alu_cout_i(alu_cout_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_out_o(res_out_o), .res_cout_o(res_cout_o)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] instr;
    logic       cin;
    logic       uc;
  } op_t;
  op_t        m_q[$];
  logic       m_rv = 1'b0;
  logic       m_carry = 1'b0;
  logic [3:0] m_out = '0;
  logic       m_cout = 1'b0;
  bit         started = 0;

  // Model: ops leave in push order; carry flag is the carry-out of the last op issued.
  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_q.delete();
      m_rv = 1'b0;
      m_carry = 1'b0;
      m_out = '0;
      m_cout = 1'b0;
    end else begin
      bit psh;
      bit iss;
      logic [4:0] r;
      op_t op;
      psh = in_valid_i && (m_q.size() != D);
      iss = (m_q.size() > 0) && (!m_rv || res_ready_i);
      if (iss) begin
        op = m_q.pop_front();
        r = alu(op.a, op.b, op.instr, op.uc ? m_carry : op.cin);
        m_out = r[3:0];
        m_cout = r[4];
        m_carry = r[4];
        m_rv = 1'b1;
      end else if (m_rv && res_ready_i) begin
        m_rv = 1'b0;
      end
      if (psh) m_q.push_back('{in_a_i, in_b_i, in_instr_i, in_cin_i, in_use_carry_i});
    end
  end

  always @(negedge clk) begin
    op_t h;
    logic [3:0] ea, eb, ei;
    logic ec;
    if (started) begin
      ea = '0; eb = '0; ei = '0; ec = 1'b0;
      if (m_q.size() > 0) begin
        h = m_q[0];
        ea = h.a; eb = h.b; ei = h.instr;
        ec = h.uc ? m_carry : h.cin;
      end
      chk("in_ready", {7'b0, in_ready_o}, {7'b0, m_q.size() != D});
      chk("res_valid", {7'b0, res_valid_o}, {7'b0, m_rv});
      chk("res_out", {4'b0, res_out_o}, {4'b0, m_out});
      chk("res_cout", {7'b0, res_cout_o}, {7'b0, m_cout});
      chk("alu_a", {4'b0, alu_a_o}, {4'b0, ea});
      chk("alu_b", {4'b0, alu_b_o}, {4'b0, eb});
      chk("alu_instr", {4'b0, alu_instr_o}, {4'b0, ei});
      chk("alu_cin", {7'b0, alu_cin_o}, {7'b0, ec});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] instr, input logic cin, input logic uc);
    bit ok;
    ok = 0;
    in_a_i = a; in_b_i = b; in_instr_i = instr; in_cin_i = cin; in_use_carry_i = uc;
    in_valid_i = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = in_ready_o;
      step();
    end
    in_valid_i = 1'b0;
    chk("push_accepted", {7'b0, ok}, 8'd1);
  endtask

  initial begin
    int acc;
    bit ok;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_res_valid", {7'b0, res_valid_o}, 8'd0);
    chk("rst_in_ready", {7'b0, in_ready_o}, 8'd1);
    chk("rst_alu_a", {4'b0, alu_a_o}, 8'd0);
    chk("rst_alu_cin", {7'b0, alu_cin_o}, 8'd0);
    chk("rst_res_out", {4'b0, res_out_o}, 8'd0);
    reset = 1'b0;
    // single op: F + 1 wraps to 0 with carry-out
    push_op(4'hF, 4'h1, 4'h0, 1'b0, 1'b0);
    chk("single_no_bypass", {7'b0, res_valid_o}, 8'd0);
    chk("single_head_a", {4'b0, alu_a_o}, 8'h0F);
    step();
    chk("single_valid", {7'b0, res_valid_o}, 8'd1);
    chk("single_out", {4'b0, res_out_o}, 8'h00);
    chk("single_cout", {7'b0, res_cout_o}, 8'd1);
    step();
    // carry chain: second op consumes the first op's carry-out
    push_op(4'hF, 4'h1, 4'h0, 1'b0, 1'b0);
    push_op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("chain_first_out", {4'b0, res_out_o}, 8'h00);
    chk("chain_cin", {7'b0, alu_cin_o}, 8'd1);
    step();
    chk("chain_out", {4'b0, res_out_o}, 8'h01);
    chk("chain_cout", {7'b0, res_cout_o}, 8'd0);
    repeat (2) step();
    // backpressure: 6 offered, DEPTH+1 accepted
    res_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_a_i = 4'(acc); in_b_i = 4'(acc + 5); in_instr_i = {3'b0, acc[0]};
      in_cin_i = 1'b0; in_use_carry_i = 1'b0;
      in_valid_i = (acc < 6);
      ok = in_ready_o && in_valid_i;
      step();
      if (ok) acc++;
    end
    in_valid_i = 1'b0;
    chk("bp_accepted", 8'(acc), 8'd5);
    chk("bp_full", {7'b0, in_ready_o}, 8'd0);
    chk("bp_first_out", {4'b0, res_out_o}, 8'h05);
    res_ready_i = 1'b1;
    step();
    chk("bp_ready_back", {7'b0, in_ready_o}, 8'd1);
    chk("bp_second_out", {4'b0, res_out_o}, 8'h07);
    repeat (3) step();
    chk("bp_last_out", {4'b0, res_out_o}, 8'h0D);
    step();
    chk("bp_drained", {7'b0, res_valid_o}, 8'd0);
    // simultaneous push/pop with two entries queued, streaming across pointer wrap
    res_ready_i = 1'b0;
    push_op(4'h2, 4'h3, 4'h0, 1'b1, 1'b0);
    push_op(4'h9, 4'h9, 4'h0, 1'b0, 1'b0);
    push_op(4'h1, 4'h1, 4'h0, 1'b0, 1'b1);
    chk("stream_pre_depth", 8'(m_q.size()), 8'd2);
    res_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a_i = 4'(i * 3); in_b_i = 4'(15 - i); in_instr_i = (i % 3 == 0) ? 4'h1 : 4'h0;
      in_cin_i = 1'b0; in_use_carry_i = i[0];
      in_valid_i = 1'b1;
      ok = in_ready_o;
      step();
      chk("stream_accept", {7'b0, ok}, 8'd1);
      chk("stream_depth", 8'(m_q.size()), 8'd2);
    end
    in_valid_i = 1'b0;
    repeat (5) step();
    // reset mid-operation: carry flag set, result pending, three queued
    res_ready_i = 1'b0;
    push_op(4'hF, 4'h1, 4'h0, 1'b0, 1'b0);
    push_op(4'h1, 4'h2, 4'h0, 1'b0, 1'b0);
    push_op(4'h3, 4'h4, 4'h0, 1'b0, 1'b0);
    push_op(4'h5, 4'h6, 4'h0, 1'b0, 1'b0);
    chk("mid_pending", {7'b0, res_valid_o}, 8'd1);
    chk("mid_cout", {7'b0, res_cout_o}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", {7'b0, res_valid_o}, 8'd0);
    chk("mid_rst_ready", {7'b0, in_ready_o}, 8'd1);
    chk("mid_rst_alu_a", {4'b0, alu_a_o}, 8'd0);
    chk("mid_rst_out", {4'b0, res_out_o}, 8'd0);
    chk("mid_rst_cout", {7'b0, res_cout_o}, 8'd0);
    res_ready_i = 1'b1;
    push_op(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("post_rst_cin", {7'b0, alu_cin_o}, 8'd0);
    step();
    chk("post_rst_valid", {7'b0, res_valid_o}, 8'd1);
    chk("post_rst_out", {4'b0, res_out_o}, 8'h00);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
